seq_shift_add_mul: RTL and testbench
====================================

// Module: seq_shift_add_mul
// PURPOSE
//  Parametrised sequential multiplier (shift-and-add), successor to the repeated-addition MUL datapath/controller pair.
//  Single self-contained block: operands on separate ports, start/busy/done handshake, signed or unsigned mode,
//  optional early termination. Sits between an operand source FSM and a result consumer; one product in flight.
// PARAMETERS
//  WIDTH       16  operand width in bits (>=2); product is 2*WIDTH bits
//  SIGNED      0   0: operands/product unsigned; 1: two's-complement operands/product
//  EARLY_TERM  1   1: stop iterating once remaining multiplier bits are all zero; 0: always WIDTH iterations
// PORTS
//  clk      in   1         rising-edge clock
//  rst_n    in   1         asynchronous active-low reset
//  start    in   1         request; sampled only when busy=0
//  a        in   WIDTH     multiplicand, sampled on accepted start edge
//  b        in   WIDTH     multiplier, sampled on accepted start edge
//  busy     out  1         high from the edge after accepted start until the edge that raises done
//  done     out  1         one-cycle pulse: product valid
//  product  out  2*WIDTH   result; held stable from done until next done
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, busy=0, done=0, product=0, internal regs=0. Mid-operation reset aborts; no done follows.
//  States: IDLE -> CALC -> FIX -> IDLE.
//   IDLE: busy=0. On edge with start=1: ma<={WIDTH'b0,|a|}, mb<=|b|, acc<=0, cnt<=0, neg<=SIGNED&(a[W-1]^b[W-1]) -> CALC.
//         With SIGNED=0, |x|=x. With SIGNED=1, |x| is the W-bit unsigned magnitude (|-2^(W-1)| = 2^(W-1) fits).
//   CALC: each edge: if cnt==WIDTH or (EARLY_TERM and mb==0) -> FIX, no update;
//         else acc<=acc+(mb[0]?ma:0) (2*WIDTH bits, never overflows), ma<=ma<<1, mb<=mb>>1, cnt<=cnt+1.
//         cnt is $clog2(WIDTH+1) bits.
//   FIX:  product<=neg ? -acc : acc (2*WIDTH two's complement); done<=1; -> IDLE.
//  done: registered, high exactly one cycle (first IDLE cycle after FIX); cleared next edge.
//  Latency: start sampled at edge k, done high after edge k+n+2, where
//   n = WIDTH if EARLY_TERM=0, else bit-length of |b| (0 for b=0).
//  busy: 1 after edge k through edge k+n+2 (deasserts when done rises).
//  Handshake: start while busy=1 is ignored (operands not sampled, no queuing). start during the done cycle is accepted
//   (back-to-back; product holds old value until the new done). start held high restarts on every IDLE cycle.
//  a/b may change freely after the accepting edge. product never changes except on the FIX edge or reset.
//  Boundary: a=0 or b=0 -> product 0, neg forced irrelevant (-0=0). SIGNED=1: (-2^(W-1))*(-2^(W-1)) = 2^(2W-2), exact.
// TESTING
//  1 WIDTH=16,SIGNED=0,EARLY_TERM=1: a=17,b=5 start@k -> done after edge k+5, product=85, busy 1 for edges k+1..k+5.
//  2 Same, EARLY_TERM=0: a=16'hFFFF,b=16'hFFFF -> product=32'hFFFE0001, done after edge k+18.
//  3 SIGNED=1: a=-3,b=7 -> product=32'hFFFFFFEB; a=16'h8000,b=16'h8000 -> 32'h40000000; a=-1,b=-1 -> 1.
//  4 b=0 (EARLY_TERM=1) -> done after edge k+2, product=0; then start during done with a=3,b=4 -> next product=12.
//  5 start re-pulsed while busy with a=9,b=9 -> ignored, first product (17*5=85) delivered unchanged, single done.
//  6 rst_n low mid-CALC -> busy=0,done=0,product=0 immediately (async); no done afterward; next start runs normally.

Source files
------------

// File: rtl/seq_shift_add_mul.sv
// Sequential shift-and-add multiplier with start/busy/done handshake,
// optional two's-complement operands and early termination on an exhausted multiplier.
module seq_shift_add_mul #(
   parameter int WIDTH      = 16,
   parameter int SIGNED     = 0,
   parameter int EARLY_TERM = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [2*WIDTH-1:0]   ma;
   logic [2*WIDTH-1:0]   acc;
   logic [WIDTH-1:0]     mb;
   logic [CNT_W-1:0]     cnt;
   logic                 neg;
   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;
   logic                 calc_end;

   // Magnitudes are WIDTH-bit unsigned, so the most negative operand maps to 2^(WIDTH-1) without overflow.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      a_mag = a;
      b_mag = b;
      if (SIGNED != 0 && a[WIDTH-1]) a_mag = ~a + WIDTH'(1);
      if (SIGNED != 0 && b[WIDTH-1]) b_mag = ~b + WIDTH'(1);
   end

   assign calc_end = (cnt == CNT_MAX) || ((EARLY_TERM != 0) && (mb == '0));

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = CALC;
         end
         CALC: begin
            busy = 1'b1;
            if (calc_end) state_nxt = FIX;
         end
         FIX: begin
            busy      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ma      <= '0;
         mb      <= '0;
         acc     <= '0;
         cnt     <= '0;
         neg     <= 1'b0;
         done    <= 1'b0;
         product <= '0;
      end else begin
         done <= (state == FIX);
         case (state)
            IDLE: begin
               if (start) begin
                  ma  <= {{WIDTH{1'b0}}, a_mag};
                  mb  <= b_mag;
                  acc <= '0;
                  cnt <= '0;
                  neg <= (SIGNED != 0) && (a[WIDTH-1] ^ b[WIDTH-1]);
               end
            end
            CALC: begin
               if (!calc_end) begin
                  acc <= acc + (mb[0] ? ma : '0);
                  ma  <= ma << 1;
                  mb  <= mb >> 1;
                  cnt <= cnt + CNT_W'(1);
               end
            end
            FIX: begin
               // A zero magnitude negates to zero, so the sign flag needs no special case.
               product <= neg ? ('0 - acc) : acc;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Self-checking bench for seq_shift_add_mul: four parameter variants driven with directed and
// random operands, compared against plain-arithmetic products and a latency formula.
module tb_seq_shift_add_mul;

   localparam int W = 16;
   localparam int N_DUT = 4;

   logic              clk;
   logic              rst_n;
   logic              start_v   [N_DUT];
   logic [W-1:0]      a_v       [N_DUT];
   logic [W-1:0]      b_v       [N_DUT];
   logic              busy_v    [N_DUT];
   logic              done_v    [N_DUT];
   logic [2*W-1:0]    product_v [N_DUT];
   logic [2*W-1:0]    prev_prod [N_DUT];

   int n_checks;
   int n_fail;

   // Variants: 0 unsigned/early, 1 unsigned/full, 2 signed/early, 3 signed/full.
   seq_shift_add_mul #(.WIDTH(W), .SIGNED(0), .EARLY_TERM(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .product(product_v[0]));
   seq_shift_add_mul #(.WIDTH(W), .SIGNED(0), .EARLY_TERM(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .product(product_v[1]));
   seq_shift_add_mul #(.WIDTH(W), .SIGNED(1), .EARLY_TERM(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
      .busy(busy_v[2]), .done(done_v[2]), .product(product_v[2]));
   seq_shift_add_mul #(.WIDTH(W), .SIGNED(1), .EARLY_TERM(0)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start_v[3]), .a(a_v[3]), .b(b_v[3]),
      .busy(busy_v[3]), .done(done_v[3]), .product(product_v[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit is_signed(int d);
      return d >= 2;
   endfunction

   function automatic bit is_early(int d);
      return (d % 2) == 0;
   endfunction

   function automatic logic [2*W-1:0] ref_prod(int d, logic [W-1:0] av, logic [W-1:0] bv);
      longint sa;
      longint sb;
      longint p;
      if (is_signed(d)) begin
         sa = longint'($signed(av));
         sb = longint'($signed(bv));
      end else begin
         sa = longint'(av);
         sb = longint'(bv);
      end
      p = sa * sb;
      return p[2*W-1:0];
   endfunction

   // Iterations: full width, or bit-length of |b| when terminating early.
   function automatic int ref_iters(int d, logic [W-1:0] bv);
      longint mag;
      int len;
      if (!is_early(d)) return W;
      mag = is_signed(d) ? longint'($signed(bv)) : longint'(bv);
      if (mag < 0) mag = -mag;
      len = 0;
      while (mag != 0) begin
         len++;
         mag = mag / 2;
      end
      return len;
   endfunction

   task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called just after a rising edge; raises start for the next edge, then follows the operation
   // cycle by cycle. Returns in the done cycle so a following call is a back-to-back start.
   task automatic run_op(input int d, input logic [W-1:0] av, input logic [W-1:0] bv, input bit repulse);
      logic [2*W-1:0] exp;
      int n;
      exp = ref_prod(d, av, bv);
      n   = ref_iters(d, bv);
      start_v[d] = 1'b1;
      a_v[d]     = av;
      b_v[d]     = bv;
      @(posedge clk);
      #1;
      start_v[d] = 1'b0;
      a_v[d]     = W'($urandom);
      b_v[d]     = W'($urandom);
      check($sformatf("d%0d accept busy", d), 32'(busy_v[d]), 32'd1);
      check($sformatf("d%0d accept done", d), 32'(done_v[d]), 32'd0);
      for (int i = 1; i <= n + 1; i++) begin
         @(posedge clk);
         #1;
         if (repulse && i == 2) start_v[d] = 1'b0;
         check($sformatf("d%0d step%0d busy", d, i), 32'(busy_v[d]), 32'd1);
         check($sformatf("d%0d step%0d done", d, i), 32'(done_v[d]), 32'd0);
         check($sformatf("d%0d step%0d hold", d, i), product_v[d], prev_prod[d]);
         if (repulse && i == 1) begin
            start_v[d] = 1'b1;
            a_v[d]     = 16'd9;
            b_v[d]     = 16'd9;
         end
      end
      @(posedge clk);
      #1;
      start_v[d] = 1'b0;
      check($sformatf("d%0d done", d), 32'(done_v[d]), 32'd1);
      check($sformatf("d%0d done busy", d), 32'(busy_v[d]), 32'd0);
      check($sformatf("d%0d product %h*%h", d, av, bv), product_v[d], exp);
      prev_prod[d] = exp;
   endtask

   task automatic idle_cycle(input int d);
      @(posedge clk);
      #1;
      check($sformatf("d%0d idle done", d), 32'(done_v[d]), 32'd0);
      check($sformatf("d%0d idle busy", d), 32'(busy_v[d]), 32'd0);
      check($sformatf("d%0d idle product", d), product_v[d], prev_prod[d]);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      for (int d = 0; d < N_DUT; d++) begin
         start_v[d]   = 1'b0;
         a_v[d]       = '0;
         b_v[d]       = '0;
         prev_prod[d] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < N_DUT; d++) begin
         check($sformatf("d%0d reset busy", d), 32'(busy_v[d]), 32'd0);
         check($sformatf("d%0d reset done", d), 32'(done_v[d]), 32'd0);
         check($sformatf("d%0d reset product", d), product_v[d], 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed cases
      run_op(0, 16'd17, 16'd5, 1'b0);
      idle_cycle(0);
      run_op(1, 16'hFFFF, 16'hFFFF, 1'b0);
      idle_cycle(1);
      for (int d = 2; d < N_DUT; d++) begin
         run_op(d, 16'hFFFD, 16'd7, 1'b0);
         run_op(d, 16'h8000, 16'h8000, 1'b0);
         run_op(d, 16'hFFFF, 16'hFFFF, 1'b0);
         run_op(d, 16'h0000, 16'hFFFB, 1'b0);
         run_op(d, 16'h7FFF, 16'h8000, 1'b0);
         idle_cycle(d);
      end
      run_op(0, 16'h1234, 16'h0000, 1'b0);
      run_op(0, 16'd3, 16'd4, 1'b0);
      idle_cycle(0);
      run_op(0, 16'd17, 16'd5, 1'b1);
      idle_cycle(0);
      idle_cycle(0);

      // Abort mid-calculation with an asynchronous reset
      start_v[0] = 1'b1;
      a_v[0]     = 16'h1234;
      b_v[0]     = 16'hFFFF;
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < N_DUT; d++) begin
         check($sformatf("d%0d abort busy", d), 32'(busy_v[d]), 32'd0);
         check($sformatf("d%0d abort done", d), 32'(done_v[d]), 32'd0);
         check($sformatf("d%0d abort product", d), product_v[d], 32'd0);
         prev_prod[d] = '0;
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("post-abort done %0d", i), 32'(done_v[0]), 32'd0);
      end
      run_op(0, 16'd100, 16'd200, 1'b0);
      idle_cycle(0);

      // Random operands; every third multiplier kept small to exercise early termination
      for (int i = 0; i < 60; i++) begin
         int d;
         logic [W-1:0] av;
         logic [W-1:0] bv;
         d  = int'($urandom_range(N_DUT - 1));
         av = W'($urandom);
         bv = (i % 3 == 0) ? W'($urandom_range(255)) : W'($urandom);
         run_op(d, av, bv, 1'b0);
         if ($urandom_range(1) == 1) idle_cycle(d);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
